// File: rtl/rx_restart_if.sv
// rx_restart_if: request/status bundle between the register bank / watchdog
// side and rx_restart_sequencer.
//   master modport: drives restart requests, frequency, durations, counter
//                   clear; reads core_rst/trigger_block/ready/state/cause/count.
//   slave modport : the sequencer itself.
// Optional macro OPENOFDM_RX_RESTART_PEND_TIMEOUT_EN adds pend_timeout.
interface rx_restart_if #(
  parameter int CNT_WIDTH     = 16,
  parameter int EVT_CNT_WIDTH = 16,
  parameter int FC_WIDTH      = 16
);
  logic                     sw_rst_req;
  logic                     wd_rst_req;
  logic [FC_WIDTH-1:0]      fc_in_MHz;
  logic                     demod_is_ongoing;
  logic                     fcs_out_strobe;
  logic                     defer_wd_en;
  logic [CNT_WIDTH-1:0]     rst_len;
  logic [CNT_WIDTH-1:0]     holdoff_len;
  logic                     cnt_clr;
`ifdef OPENOFDM_RX_RESTART_PEND_TIMEOUT_EN
  logic [CNT_WIDTH-1:0]     pend_timeout;
`endif
  logic                     core_rst;
  logic                     trigger_block;
  logic                     ready;
  logic [2:0]               state;
  logic [1:0]               restart_cause;
  logic [EVT_CNT_WIDTH-1:0] restart_count;

  modport master (
`ifdef OPENOFDM_RX_RESTART_PEND_TIMEOUT_EN
    output pend_timeout,
`endif
    output sw_rst_req, wd_rst_req, fc_in_MHz, demod_is_ongoing,
           fcs_out_strobe, defer_wd_en, rst_len, holdoff_len, cnt_clr,
    input  core_rst, trigger_block, ready, state, restart_cause, restart_count
  );

  modport slave (
`ifdef OPENOFDM_RX_RESTART_PEND_TIMEOUT_EN
    input  pend_timeout,
`endif
    input  sw_rst_req, wd_rst_req, fc_in_MHz, demod_is_ongoing,
           fcs_out_strobe, defer_wd_en, rst_len, holdoff_len, cnt_clr,
    output core_rst, trigger_block, ready, state, restart_cause, restart_count
  );
endinterface

// File: rtl/rx_restart_sequencer.sv
// rx_restart_sequencer: arbitrates restart sources for the dot11 receive core
// (software level > carrier-frequency change > watchdog pulse), holds the core
// in reset for rst_len cycles, then blanks the power trigger for holdoff_len
// cycles before re-arming.
// Ports:
//   clk  - clock
//   rst  - synchronous active-high reset
//   bus  - rx_restart_if.slave: requests, durations, counter clear in;
//          core_rst, trigger_block, ready, state, restart_cause,
//          restart_count out (all registered)
// Optional macro OPENOFDM_RX_RESTART_PEND_TIMEOUT_EN: PENDING times out after
// pend_timeout cycles (0 = never) into RESET with cause 3.
module rx_restart_sequencer #(
  parameter int CNT_WIDTH     = 16,
  parameter int EVT_CNT_WIDTH = 16,
  parameter int FC_WIDTH      = 16
) (
  input logic         clk,
  input logic         rst,
  rx_restart_if.slave bus
);

  typedef enum logic [2:0] {
    ARMED   = 3'd0,
    RESET   = 3'd1,
    HOLDOFF = 3'd2,
    PENDING = 3'd3,
    SW_HOLD = 3'd4
  } state_t;

  localparam logic [1:0] CAUSE_SW = 2'd0;
  localparam logic [1:0] CAUSE_FC = 2'd1;
  localparam logic [1:0] CAUSE_WD = 2'd2;
`ifdef OPENOFDM_RX_RESTART_PEND_TIMEOUT_EN
  localparam logic [1:0] CAUSE_TO = 2'd3;
`endif
  localparam logic [CNT_WIDTH-1:0]     CNT_ONE = CNT_WIDTH'(1);
  localparam logic [EVT_CNT_WIDTH-1:0] EVT_ONE = EVT_CNT_WIDTH'(1);

  state_t                   state_q, state_nxt;
  logic [CNT_WIDTH-1:0]     cnt_q, cnt_nxt;
  logic [1:0]               cause_q, cause_nxt;
  logic [EVT_CNT_WIDTH-1:0] count_q;
  logic [FC_WIDTH-1:0]      fc_q;
  logic                     fc_chg, inc, cnt_last;
  logic                     core_rst_q, trig_q, ready_q;

  assign fc_chg = (bus.fc_in_MHz != fc_q);
  // A loaded length of 0 behaves as 1: the state always lasts at least one cycle.
  assign cnt_last = (cnt_q == CNT_ONE) || (cnt_q == '0);

  always_comb begin
    state_nxt = state_q;
    cnt_nxt   = cnt_q;
    cause_nxt = cause_q;
    inc       = 1'b0;
    case (state_q)
      ARMED: begin
        if (bus.sw_rst_req) begin
          state_nxt = SW_HOLD; cause_nxt = CAUSE_SW; inc = 1'b1;
        end else if (fc_chg) begin
          state_nxt = RESET; cnt_nxt = bus.rst_len; cause_nxt = CAUSE_FC; inc = 1'b1;
        end else if (bus.wd_rst_req) begin
          if (bus.defer_wd_en && bus.demod_is_ongoing) begin
            state_nxt = PENDING;
`ifdef OPENOFDM_RX_RESTART_PEND_TIMEOUT_EN
            cnt_nxt   = bus.pend_timeout;
`endif
          end else begin
            state_nxt = RESET; cnt_nxt = bus.rst_len; cause_nxt = CAUSE_WD; inc = 1'b1;
          end
        end
      end
      PENDING: begin
        if (bus.sw_rst_req) begin
          state_nxt = SW_HOLD; cause_nxt = CAUSE_SW; inc = 1'b1;
        end else if (fc_chg) begin
          state_nxt = RESET; cnt_nxt = bus.rst_len; cause_nxt = CAUSE_FC; inc = 1'b1;
        end else if (!bus.demod_is_ongoing || bus.fcs_out_strobe) begin
          state_nxt = RESET; cnt_nxt = bus.rst_len; cause_nxt = CAUSE_WD; inc = 1'b1;
`ifdef OPENOFDM_RX_RESTART_PEND_TIMEOUT_EN
        // Counter parked at 0 means the timeout is disabled.
        end else if (cnt_q == CNT_ONE) begin
          state_nxt = RESET; cnt_nxt = bus.rst_len; cause_nxt = CAUSE_TO; inc = 1'b1;
        end else if (cnt_q != '0) begin
          cnt_nxt = cnt_q - CNT_ONE;
`endif
        end
      end
      RESET: begin
        if (bus.sw_rst_req) begin
          state_nxt = SW_HOLD; cause_nxt = CAUSE_SW; inc = 1'b1;
        end else if (fc_chg) begin
          cnt_nxt = bus.rst_len; cause_nxt = CAUSE_FC; inc = 1'b1;
        end else if (cnt_last) begin
          state_nxt = HOLDOFF; cnt_nxt = bus.holdoff_len;
        end else begin
          cnt_nxt = cnt_q - CNT_ONE;
        end
      end
      HOLDOFF: begin
        if (bus.sw_rst_req) begin
          state_nxt = SW_HOLD; cause_nxt = CAUSE_SW; inc = 1'b1;
        end else if (fc_chg) begin
          state_nxt = RESET; cnt_nxt = bus.rst_len; cause_nxt = CAUSE_FC; inc = 1'b1;
        end else if (cnt_last) begin
          state_nxt = ARMED;
        end else begin
          cnt_nxt = cnt_q - CNT_ONE;
        end
      end
      SW_HOLD: begin
        // Reset length is loaded on release so the core always gets a full reset.
        if (!bus.sw_rst_req) begin
          state_nxt = RESET; cnt_nxt = bus.rst_len; cause_nxt = CAUSE_SW;
        end
      end
      default: begin
        state_nxt = RESET; cnt_nxt = bus.rst_len; cause_nxt = CAUSE_SW;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= RESET;
      cnt_q      <= bus.rst_len;
      cause_q    <= CAUSE_SW;
      count_q    <= '0;
      fc_q       <= bus.fc_in_MHz;
      core_rst_q <= 1'b1;
      trig_q     <= 1'b1;
      ready_q    <= 1'b0;
    end else begin
      state_q    <= state_nxt;
      cnt_q      <= cnt_nxt;
      cause_q    <= cause_nxt;
      fc_q       <= bus.fc_in_MHz;
      core_rst_q <= (state_nxt == RESET) || (state_nxt == SW_HOLD);
      trig_q     <= (state_nxt != ARMED) && (state_nxt != PENDING);
      ready_q    <= (state_nxt == ARMED);
      if (bus.cnt_clr)
        count_q <= inc ? EVT_ONE : '0;
      else if (inc && (count_q != '1))
        count_q <= count_q + EVT_ONE;
    end
  end

  assign bus.core_rst      = core_rst_q;
  assign bus.trigger_block = trig_q;
  assign bus.ready         = ready_q;
  assign bus.state         = state_q;
  assign bus.restart_cause = cause_q;
  assign bus.restart_count = count_q;

endmodule

// File: tb/tb_rx_restart_sequencer.sv
// tb_rx_restart_sequencer: directed and randomized stimulus for
// rx_restart_sequencer, compared every cycle against a behavioural model.
// The event counter is built 10 bits wide so saturation is reachable quickly.
module tb_rx_restart_sequencer;
  localparam int EW   = 10;
  localparam int CMAX = (1 << EW) - 1;

  logic clk, rst;
  int   n_checks, n_fail;

  rx_restart_if #(.CNT_WIDTH(16), .EVT_CNT_WIDTH(EW), .FC_WIDTH(16)) bus ();

  rx_restart_sequencer #(.CNT_WIDTH(16), .EVT_CNT_WIDTH(EW), .FC_WIDTH(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model: state numbers 0 ARMED, 1 RESET, 2 HOLDOFF, 3 PENDING, 4 SW_HOLD
  int m_state, m_remain, m_cause, m_count, m_fcq, m_pend_lim, m_pend_el;

  function automatic int len1(input int v);
    return (v == 0) ? 1 : v;
  endfunction

  task automatic enter_reset(input int cause);
    m_state  = 1;
    m_remain = len1(int'(bus.rst_len));
    m_cause  = cause;
  endtask

  task automatic model_step();
    bit fchg, inc;
    if (rst) begin
      enter_reset(0);
      m_count = 0;
      m_fcq   = int'(bus.fc_in_MHz);
      return;
    end
    fchg  = (int'(bus.fc_in_MHz) != m_fcq);
    m_fcq = int'(bus.fc_in_MHz);
    inc   = 0;
    if (m_state != 4 && bus.sw_rst_req) begin
      m_state = 4; m_cause = 0; inc = 1;
    end else begin
      case (m_state)
        0: if (fchg) begin enter_reset(1); inc = 1; end
           else if (bus.wd_rst_req) begin
             if (bus.defer_wd_en && bus.demod_is_ongoing) begin
               m_state = 3; m_pend_el = 0; m_pend_lim = 0;
`ifdef OPENOFDM_RX_RESTART_PEND_TIMEOUT_EN
               m_pend_lim = int'(bus.pend_timeout);
`endif
             end else begin enter_reset(2); inc = 1; end
           end
        3: if (fchg) begin enter_reset(1); inc = 1; end
           else if (!bus.demod_is_ongoing || bus.fcs_out_strobe) begin enter_reset(2); inc = 1; end
           else begin
             m_pend_el++;
             if (m_pend_lim != 0 && m_pend_el == m_pend_lim) begin enter_reset(3); inc = 1; end
           end
        1: if (fchg) begin enter_reset(1); inc = 1; end
           else if (m_remain == 1) begin m_state = 2; m_remain = len1(int'(bus.holdoff_len)); end
           else m_remain--;
        2: if (fchg) begin enter_reset(1); inc = 1; end
           else if (m_remain == 1) m_state = 0;
           else m_remain--;
        default: if (!bus.sw_rst_req) enter_reset(0);
      endcase
    end
    if (bus.cnt_clr) m_count = inc ? 1 : 0;
    else if (inc && m_count < CMAX) m_count++;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_model();
    chk("state",         32'(bus.state), 32'(m_state));
    chk("core_rst",      32'(bus.core_rst), 32'(m_state == 1 || m_state == 4));
    chk("trigger_block", 32'(bus.trigger_block), 32'(!(m_state == 0 || m_state == 3)));
    chk("ready",         32'(bus.ready), 32'(m_state == 0));
    chk("restart_cause", 32'(bus.restart_cause), 32'(m_cause));
    chk("restart_count", 32'(bus.restart_count), 32'(m_count));
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    check_model();
  endtask

  // Counts core_rst / trigger_block highs in the current observation plus n more cycles.
  task automatic measure(input int n, output int c_rst, output int c_trig);
    c_rst  = int'(bus.core_rst);
    c_trig = int'(bus.trigger_block);
    for (int i = 0; i < n; i++) begin
      tick();
      c_rst  += int'(bus.core_rst);
      c_trig += int'(bus.trigger_block);
    end
  endtask

  task automatic settle();
    bus.sw_rst_req = 0; bus.wd_rst_req = 0; bus.fcs_out_strobe = 0;
    bus.demod_is_ongoing = 0; bus.defer_wd_en = 0; bus.cnt_clr = 0;
    for (int i = 0; i < 60 && m_state != 0; i++) tick();
    chk("settle_armed", 32'(bus.state), 32'd0);
  endtask

  initial begin
    int a, b, c0, p1, p2, p3;
    n_checks = 0; n_fail = 0;
    m_state = 0; m_remain = 1; m_cause = 0; m_count = 0; m_fcq = 0; m_pend_lim = 0; m_pend_el = 0;
    rst = 1;
    bus.sw_rst_req = 0; bus.wd_rst_req = 0; bus.fc_in_MHz = 16'd2412;
    bus.demod_is_ongoing = 0; bus.fcs_out_strobe = 0; bus.defer_wd_en = 0;
    bus.rst_len = 16'd4; bus.holdoff_len = 16'd3; bus.cnt_clr = 0;
`ifdef OPENOFDM_RX_RESTART_PEND_TIMEOUT_EN
    bus.pend_timeout = 16'd0;
`endif
    @(negedge clk);

    // Reset release: 4 cycles of core reset, 3 more of trigger blanking, then armed.
    tick(); tick();
    rst = 0;
    measure(11, a, b);
    chk("rst_release_core_rst_cycles", 32'(a), 32'd4);
    chk("rst_release_trigger_cycles", 32'(b), 32'd7);
    chk("rst_release_ready", 32'(bus.ready), 32'd1);
    chk("rst_release_count", 32'(bus.restart_count), 32'd0);

    // Undeferred watchdog pulse.
    bus.wd_rst_req = 1; tick(); bus.wd_rst_req = 0;
    chk("wd_cause", 32'(bus.restart_cause), 32'd2);
    chk("wd_count", 32'(bus.restart_count), 32'd1);
    measure(10, a, b);
    chk("wd_core_rst_cycles", 32'(a), 32'd4);

    // Deferred watchdog: PENDING until packet end, extra pulses absorbed.
    bus.defer_wd_en = 1; bus.demod_is_ongoing = 1;
    bus.wd_rst_req = 1; tick(); bus.wd_rst_req = 0;
    chk("defer_state_pending", 32'(bus.state), 32'd3);
    chk("defer_core_rst_low", 32'(bus.core_rst), 32'd0);
    p1 = int'($urandom_range(2, 15)); p2 = int'($urandom_range(16, 30)); p3 = int'($urandom_range(31, 45));
    for (int i = 0; i < 49; i++) begin
      bus.wd_rst_req = (i == p1 || i == p2 || i == p3);
      tick();
    end
    bus.wd_rst_req = 0;
    bus.fcs_out_strobe = 1; tick(); bus.fcs_out_strobe = 0;
    chk("defer_exit_state", 32'(bus.state), 32'd1);
    chk("defer_exit_cause", 32'(bus.restart_cause), 32'd2);
    chk("defer_exit_count", 32'(bus.restart_count), 32'd2);
    settle();

    // Frequency change during the second RESET cycle restarts the reset window.
    c0 = m_count;
    bus.wd_rst_req = 1; tick(); bus.wd_rst_req = 0;
    tick();
    bus.fc_in_MHz = 16'd2437; tick();
    chk("fc_cause", 32'(bus.restart_cause), 32'd1);
    chk("fc_count", 32'(bus.restart_count), 32'(c0 + 2));
    measure(10, a, b);
    chk("fc_extended_reset_cycles", 32'(a), 32'd4);
    settle();
    bus.rst_len = 16'd0;
    bus.wd_rst_req = 1; tick(); bus.wd_rst_req = 0;
    measure(5, a, b);
    chk("rst_len0_cycles", 32'(a), 32'd1);
    bus.rst_len = 16'd4;
    settle();

    // Software reset during HOLDOFF with a simultaneous frequency change.
    bus.wd_rst_req = 1; tick(); bus.wd_rst_req = 0;
    for (int i = 0; i < 20 && m_state != 2; i++) tick();
    c0 = m_count;
    bus.sw_rst_req = 1; bus.fc_in_MHz = 16'd2462;
    a = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      a += int'(bus.state == 3'd4);
    end
    chk("sw_hold_cycles", 32'(a), 32'd10);
    bus.sw_rst_req = 0; tick();
    chk("sw_release_cause", 32'(bus.restart_cause), 32'd0);
    measure(10, a, b);
    chk("sw_release_reset_cycles", 32'(a), 32'd4);
    chk("sw_count_once", 32'(bus.restart_count), 32'(c0 + 1));

    // Randomized traffic, including mid-state length changes and counter clears.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 39) == 0) bus.sw_rst_req = ~bus.sw_rst_req;
      bus.wd_rst_req     = ($urandom_range(0, 15) == 0);
      bus.fcs_out_strobe = ($urandom_range(0, 19) == 0);
      bus.cnt_clr        = ($urandom_range(0, 49) == 0);
      if ($urandom_range(0, 9) == 0) bus.demod_is_ongoing = ~bus.demod_is_ongoing;
      if ($urandom_range(0, 7) == 0) bus.defer_wd_en = ~bus.defer_wd_en;
      if ($urandom_range(0, 24) == 0) bus.fc_in_MHz = 16'(2412 + 25 * $urandom_range(0, 2));
      if ($urandom_range(0, 29) == 0) bus.rst_len = 16'($urandom_range(0, 5));
      if ($urandom_range(0, 29) == 0) bus.holdoff_len = 16'($urandom_range(0, 5));
      tick();
    end
    bus.rst_len = 16'd4; bus.holdoff_len = 16'd3;
    settle();

    // Saturation: a frequency change every cycle inside RESET counts every cycle.
    bus.wd_rst_req = 1; tick(); bus.wd_rst_req = 0;
    for (int i = 0; i < CMAX + 20; i++) begin
      bus.fc_in_MHz = (bus.fc_in_MHz == 16'd2412) ? 16'd2437 : 16'd2412;
      tick();
    end
    chk("count_saturated", 32'(bus.restart_count), 32'(CMAX));
    settle();
    chk("count_still_saturated", 32'(bus.restart_count), 32'(CMAX));
    bus.cnt_clr = 1; bus.wd_rst_req = 1; tick();
    bus.cnt_clr = 0; bus.wd_rst_req = 0;
    chk("clr_with_inc", 32'(bus.restart_count), 32'd1);
    settle();
    bus.cnt_clr = 1; tick(); bus.cnt_clr = 0;
    chk("clr_alone", 32'(bus.restart_count), 32'd0);

`ifdef OPENOFDM_RX_RESTART_PEND_TIMEOUT_EN
    // PENDING timeout after 20 cycles.
    bus.pend_timeout = 16'd20;
    bus.defer_wd_en = 1; bus.demod_is_ongoing = 1;
    bus.wd_rst_req = 1; tick(); bus.wd_rst_req = 0;
    a = 0;
    for (int i = 0; i < 100 && bus.state == 3'd3; i++) begin
      a++;
      tick();
    end
    chk("pend_timeout_cycles", 32'(a), 32'd20);
    chk("pend_timeout_cause", 32'(bus.restart_cause), 32'd3);
    bus.pend_timeout = 16'd0;
    settle();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
